down_sampling_2x2: RTL and testbench

//  2x2 stride-2 max-pool over a channel-interleaved feature-map stream (pixel-major, CHANNEL_NUM beats/pixel).

---
 rtl/cnn_stream_pkg.sv | 29 ++
 rtl/down_sampling_2x2_ram.sv | 32 +++
 rtl/down_sampling_2x2.sv | 235 +++++++++++++++++++++++
 tb/tb_down_sampling_2x2.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_stream_pkg.sv
// Shared helpers for the CNN feature-map streaming blocks: the signed max used
// by the pooling stages, the framing flag bundle and a safe width helper.
package cnn_stream_pkg;

  // Width that smax works in; callers sign-extend into it and truncate back.
  localparam int SMAX_W = 32;

  // Framing flags carried alongside each pooled sample.
  typedef struct packed {
    logic sop;
    logic eop;
    logic sof;
    logic eof;
  } frame_flags_t;

  // $clog2 that never returns zero, so counters for size-1 dimensions still get a bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Signed maximum. On a tie either operand is correct, so a is returned.
  function automatic logic signed [SMAX_W-1:0] smax(
    input logic signed [SMAX_W-1:0] a,
    input logic signed [SMAX_W-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/down_sampling_2x2_ram.sv
// Simple dual-port line-buffer RAM with a registered (1-clk) read port.
// Contents are not reset; every location is written before it is read.
module down_sampling_2x2_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  (* ramstyle = "M10K" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port plus registered read port, kept free of reset so it maps to block RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/down_sampling_2x2.sv
// 2x2 stride-2 signed max-pool over a channel-interleaved pixel stream.
// Horizontal pairs are reduced in a per-channel register, vertical pairs via a
// one-line buffer RAM; output appears 2 clocks after the triggering input beat.
// Optional build macro: DOWN_SAMPLING_RELU_EN fuses a ReLU onto the output.
module down_sampling_2x2
  import cnn_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int STRING_LEN   = 224,
  parameter int STRING_NUM   = STRING_LEN,
  parameter int CHANNEL_NUM  = 3,
  parameter int DATA_O_WIDTH = DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    valid_i,
  input  logic                    sop_i,
  input  logic                    eop_i,
  input  logic                    sof_i,
  input  logic                    eof_i,
  output logic [DATA_O_WIDTH-1:0] data_o,
  output logic                    data_valid_o,
  output logic                    sop_o,
  output logic                    eop_o,
  output logic                    sof_o,
  output logic                    eof_o
);

  localparam int CHAN_W    = clog2_min1(CHANNEL_NUM);
  localparam int COL_W     = clog2_min1(STRING_LEN);
  localparam int ROW_W     = clog2_min1(STRING_NUM);
  localparam int LB_DEPTH  = STRING_LEN / 2 * CHANNEL_NUM;
  localparam int LB_ADDR_W = clog2_min1(LB_DEPTH);

  localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(CHANNEL_NUM - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(STRING_LEN - 1);
  localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(STRING_NUM - 1);
  localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);

  // Odd dimensions cannot be pooled 2x2 without a ragged edge.
  if (STRING_LEN % 2 != 0) begin : g_len_odd
    $error("down_sampling_2x2: STRING_LEN must be even");
  end
  if (STRING_NUM % 2 != 0) begin : g_num_odd
    $error("down_sampling_2x2: STRING_NUM must be even");
  end
  if (DATA_WIDTH > SMAX_W) begin : g_dw_wide
    $error("down_sampling_2x2: DATA_WIDTH exceeds smax width");
  end

  // Input eop/eof are redundant with the counters; output framing is derived locally.
  logic w_unused_flags;
  assign w_unused_flags = ^{eop_i, eof_i};

  // ---------------------------------------------------------------- counters
  logic [CHAN_W-1:0] r_chan, w_chan, w_chan_next;
  logic [COL_W-1:0]  r_col,  w_col,  w_col_next;
  logic [ROW_W-1:0]  r_row,  w_row,  w_row_next;

  // Effective position of the current beat: sop/sof realign, dropping any partial pair.
  always_comb begin
    w_chan = r_chan;
    w_col  = r_col;
    w_row  = r_row;
    if (valid_i && (sop_i || sof_i)) begin
      w_chan = '0;
      w_col  = '0;
    end
    if (valid_i && sof_i) begin
      w_row = '0;
    end
  end

  // Position of the beat that follows: channel, then column, then row wrap.
  always_comb begin
    w_chan_next = w_chan;
    w_col_next  = w_col;
    w_row_next  = w_row;
    if (w_chan == CHAN_LAST) begin
      w_chan_next = '0;
      if (w_col == COL_LAST) begin
        w_col_next = '0;
        w_row_next = (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
      end else begin
        w_col_next = w_col + 1'b1;
      end
    end else begin
      w_chan_next = w_chan + 1'b1;
    end
  end

  // Position counters advance only on qualified beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chan <= '0;
      r_col  <= '0;
      r_row  <= '0;
    end else if (valid_i) begin
      r_chan <= w_chan_next;
      r_col  <= w_col_next;
      r_row  <= w_row_next;
    end
  end

  // -------------------------------------------------------- horizontal stage
  logic signed [DATA_WIDTH-1:0] w_hmax [CHANNEL_NUM];
  logic signed [DATA_WIDTH-1:0] w_hmax_sel;
  logic signed [DATA_WIDTH-1:0] w_h;

  for (genvar gi = 0; gi < CHANNEL_NUM; gi++) begin : g_hmax
    logic signed [DATA_WIDTH-1:0] r_hmax;

    // Hold this channel's even-column sample until its odd-column partner arrives.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_hmax <= '0;
      end else if (valid_i && !w_col[0] && (w_chan == CHAN_W'(gi))) begin
        r_hmax <= $signed(data_i);
      end
    end

    assign w_hmax[gi] = r_hmax;
  end

  // Pick the held even-column sample of the current beat's channel.
  always_comb begin
    w_hmax_sel = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (w_chan == CHAN_W'(i)) begin
        w_hmax_sel = w_hmax[i];
      end
    end
  end

  assign w_h = DATA_WIDTH'(smax(SMAX_W'(w_hmax_sel), SMAX_W'($signed(data_i))));

  // ---------------------------------------------------------- vertical stage
  // Even rows park the horizontal max; odd rows read it back on the odd-column
  // beat itself. Reading on that beat (rather than on the even-column beat)
  // keeps the RAM output private to one channel even when the channels of a
  // pixel pair are interleaved between the two reads.
  logic                 w_odd_pair;
  logic                 w_lb_wr_en;
  logic                 w_lb_rd_en;
  logic [LB_ADDR_W-1:0] w_lb_addr;
  logic [DATA_WIDTH-1:0] w_lb_q;

  assign w_odd_pair = valid_i && w_col[0];
  assign w_lb_wr_en = w_odd_pair && !w_row[0];
  assign w_lb_rd_en = w_odd_pair &&  w_row[0];
  assign w_lb_addr  = LB_ADDR_W'((32'(w_col) >> 1) * CHANNEL_NUM + 32'(w_chan));

  down_sampling_2x2_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (LB_ADDR_W),
    .DEPTH      (LB_DEPTH)
  ) u_line_buf (
    .i_clk     (clk),
    .i_wr_en   (w_lb_wr_en),
    .i_wr_addr (w_lb_addr),
    .i_wr_data (w_h),
    .i_rd_en   (w_lb_rd_en),
    .i_rd_addr (w_lb_addr),
    .o_rd_data (w_lb_q)
  );

  // Output framing for a triggering beat (odd row, odd column).
  frame_flags_t w_flags;
  always_comb begin
    w_flags.sop = (w_col == COL_ONE)  && (w_chan == '0);
    w_flags.eop = (w_col == COL_LAST) && (w_chan == CHAN_LAST);
    w_flags.sof = w_flags.sop && (w_row == ROW_ONE);
    w_flags.eof = w_flags.eop && (w_row == ROW_LAST);
  end

  // --------------------------------------------------------- output pipeline
  logic                         r_s1_valid;
  logic signed [DATA_WIDTH-1:0] r_s1_h;
  frame_flags_t                 r_s1_flags;

  // Stage 1: capture the horizontal max while the line-buffer read is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_h     <= '0;
      r_s1_flags <= '0;
    end else begin
      r_s1_valid <= w_lb_rd_en;
      if (w_lb_rd_en) begin
        r_s1_h     <= w_h;
        r_s1_flags <= w_flags;
      end
    end
  end

  logic signed [DATA_WIDTH-1:0] w_pool;
  logic signed [DATA_WIDTH-1:0] w_res;

  assign w_pool = DATA_WIDTH'(smax(SMAX_W'(r_s1_h), SMAX_W'($signed(w_lb_q))));

`ifdef DOWN_SAMPLING_RELU_EN
  assign w_res = w_pool[DATA_WIDTH-1] ? '0 : w_pool;
`else
  assign w_res = w_pool;
`endif

  logic [DATA_O_WIDTH-1:0] r_data_o;
  logic                    r_valid_o;
  frame_flags_t            r_flags_o;

  // Stage 2: combine with the row above and register the outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_o  <= '0;
      r_valid_o <= 1'b0;
      r_flags_o <= '0;
    end else begin
      r_valid_o <= r_s1_valid;
      r_flags_o <= r_s1_valid ? r_s1_flags : '0;
      if (r_s1_valid) begin
        r_data_o <= DATA_O_WIDTH'(w_res);
      end
    end
  end

  assign data_o       = r_data_o;
  assign data_valid_o = r_valid_o;
  assign sop_o        = r_flags_o.sop;
  assign eop_o        = r_flags_o.eop;
  assign sof_o        = r_flags_o.sof;
  assign eof_o        = r_flags_o.eof;

endmodule

// File: tb/tb_down_sampling_2x2.sv
// Directed bench for down_sampling_2x2 on a 4x4x3 frame geometry.
module tb_down_sampling_2x2;

  localparam int DW  = 8;
  localparam int LEN = 4;
  localparam int NUM = 4;
  localparam int CH  = 3;
  localparam int FRAME_BEATS = LEN * NUM * CH;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] data_i  = '0;
  logic          valid_i = 1'b0;
  logic          sop_i   = 1'b0;
  logic          eop_i   = 1'b0;
  logic          sof_i   = 1'b0;
  logic          eof_i   = 1'b0;
  logic [DW-1:0] data_o;
  logic          data_valid_o, sop_o, eop_o, sof_o, eof_o;

  down_sampling_2x2 #(
    .DATA_WIDTH   (DW),
    .STRING_LEN   (LEN),
    .STRING_NUM   (NUM),
    .CHANNEL_NUM  (CH),
    .DATA_O_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .sop_i        (sop_i),
    .eop_i        (eop_i),
    .sof_i        (sof_i),
    .eof_i        (eof_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .sop_o        (sop_o),
    .eop_o        (eop_o),
    .sof_o        (sof_o),
    .eof_o        (eof_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end else begin
      $display("ok   %s: %0d", tag, $signed(got));
    end
  endtask

  typedef struct { int data; logic [3:0] flg; int cyc; } obs_t;
  typedef struct { int data; logic [3:0] flg; } exp_t;
  obs_t obs_q[$];
  exp_t exp_q[$];
  int   trig_q[$];
  int   frm [NUM][LEN][CH];

  always @(negedge clk) begin : monitor
    obs_t o;
    if (data_valid_o) begin
      o.data = int'($signed(data_o));
      o.flg  = {sop_o, eop_o, sof_o, eof_o};
      o.cyc  = cyc;
      obs_q.push_back(o);
    end
  end

  function automatic int relu_tb(input int v);
`ifdef DOWN_SAMPLING_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic push_exp(input int v, input int orow, input int ocol, input int ch);
    exp_t e;
    logic s, p;
    s = (ocol == 0) && (ch == 0);
    p = (ocol == LEN/2 - 1) && (ch == CH - 1);
    e.data = relu_tb(v);
    e.flg  = {s, p, s && (orow == 0), p && (orow == NUM/2 - 1)};
    exp_q.push_back(e);
  endtask

  // Expected outputs taken straight from the 2x2 windows of the stored frame.
  task automatic push_model();
    int m;
    for (int r = 0; r < NUM/2; r++)
      for (int c = 0; c < LEN/2; c++)
        for (int ch = 0; ch < CH; ch++) begin
          m = frm[2*r][2*c][ch];
          if (frm[2*r][2*c+1][ch]   > m) m = frm[2*r][2*c+1][ch];
          if (frm[2*r+1][2*c][ch]   > m) m = frm[2*r+1][2*c][ch];
          if (frm[2*r+1][2*c+1][ch] > m) m = frm[2*r+1][2*c+1][ch];
          push_exp(m, r, c, ch);
        end
  endtask

  task automatic send_frame(input int max_gap, input int n_beats);
    for (int b = 0; b < n_beats; b++) begin
      int row, col, ch, gap;
      row = b / (LEN * CH);
      col = (b / CH) % LEN;
      ch  = b % CH;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        @(negedge clk);
        valid_i = 1'b0;
      end
      @(negedge clk);
      data_i  = DW'(frm[row][col][ch]);
      valid_i = 1'b1;
      sop_i   = (col == 0) && (ch == 0);
      eop_i   = (col == LEN - 1) && (ch == CH - 1);
      sof_i   = sop_i && (row == 0);
      eof_i   = eop_i && (row == NUM - 1);
      if ((row % 2 == 1) && (col % 2 == 1)) trig_q.push_back(cyc);
    end
    @(negedge clk);
    valid_i = 1'b0;
    sop_i = 1'b0; eop_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
  endtask

  task automatic compare_run(input string nm);
    int n;
    repeat (4) @(negedge clk);
    #1;
    check({nm, ".count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d].data", nm, i), obs_q[i].data, exp_q[i].data);
      check($sformatf("%s[%0d].flags", nm, i), 32'(obs_q[i].flg), 32'(exp_q[i].flg));
      if (i < trig_q.size())
        check($sformatf("%s[%0d].latency", nm, i), obs_q[i].cyc - trig_q[i], 2);
    end
    obs_q.delete(); exp_q.delete(); trig_q.delete();
  endtask

  task automatic fill_random();
    for (int r = 0; r < NUM; r++)
      for (int c = 0; c < LEN; c++)
        for (int ch = 0; ch < CH; ch++)
          frm[r][c][ch] = int'($urandom_range(255, 0)) - 128;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int hv [4][CH];

    repeat (3) @(negedge clk);
    check("reset.outputs", 32'({data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o}), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ramp frame: ch0=+p, ch1=-p, ch2=9, continuous valid.
    for (int r = 0; r < NUM; r++)
      for (int c = 0; c < LEN; c++) begin
        frm[r][c][0] = r * LEN + c;
        frm[r][c][1] = -(r * LEN + c);
        frm[r][c][2] = 9;
      end
    hv = '{'{5, 0, 9}, '{7, -2, 9}, '{13, -8, 9}, '{15, -10, 9}};
    for (int k = 0; k < 4; k++)
      for (int ch = 0; ch < CH; ch++) push_exp(hv[k][ch], k / 2, k % 2, ch);
    send_frame(0, FRAME_BEATS);
    compare_run("ramp");

    // Negative windows, most-negative value and ties.
    for (int r = 0; r < NUM; r++)
      for (int c = 0; c < LEN; c++) begin
        frm[r][c][0] = -128;
        frm[r][c][1] = 127;
        frm[r][c][2] = 4;
      end
    frm[0][0][0] = -128; frm[0][1][0] = -1; frm[1][0][0] = -2; frm[1][1][0] = -3;
    frm[0][2][0] = -5;   frm[0][3][0] = 3;  frm[1][2][0] = 0;  frm[1][3][0] = 2;
    hv = '{'{-1, 127, 4}, '{3, 127, 4}, '{-128, 127, 4}, '{-128, 127, 4}};
    for (int k = 0; k < 4; k++)
      for (int ch = 0; ch < CH; ch++) push_exp(hv[k][ch], k / 2, k % 2, ch);
    send_frame(0, FRAME_BEATS);
    compare_run("neg");

    // Random data with bursty valid gaps.
    for (int f = 0; f < 3; f++) begin
      fill_random();
      push_model();
      send_frame(5, FRAME_BEATS);
      compare_run($sformatf("gap%0d", f));
    end

    // Abandoned partial frame followed by a fresh sof.
    for (int r = 0; r < NUM; r++)
      for (int c = 0; c < LEN; c++)
        for (int ch = 0; ch < CH; ch++) frm[r][c][ch] = 100 + ch;
    send_frame(0, LEN * CH + CH);
    fill_random();
    push_model();
    send_frame(2, FRAME_BEATS);
    compare_run("resof");

    // Reset mid-row right after a triggering beat.
    fill_random();
    send_frame(0, LEN * CH + 2 * CH);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst.outputs", 32'({data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    obs_q.delete(); exp_q.delete(); trig_q.delete();
    repeat (4) @(negedge clk);
    #1;
    check("midrst.flush", obs_q.size(), 0);
    obs_q.delete();
    fill_random();
    push_model();
    send_frame(1, FRAME_BEATS);
    compare_run("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
